// File: rtl/load_store_unit.sv
// load_store_unit: bridges core byte/half/word accesses to a word-aligned memory request/ready port
module load_store_unit (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i,
    input  logic        mem_ready_i
);
    typedef enum logic {IDLE, WAIT} state_t;
    state_t      state_q, state_d;
    logic        in_wait, done, is_b, is_h, sext;
    logic [7:0]  rd_b;
    logic [15:0] rd_h;
    logic [3:0]  be;
    always_comb begin
        in_wait      = state_q == WAIT;
        done         = in_wait & mem_ready_i;
        state_d      = in_wait ? (mem_ready_i ? IDLE : WAIT) : (core_req_i ? WAIT : IDLE);
        is_b         = core_size_i inside {3'd0, 3'd4};
        is_h         = core_size_i inside {3'd1, 3'd5};
        sext         = ~core_size_i[2];
        be           = is_b ? 4'b0001 << core_addr_i[1:0] : is_h ? (core_addr_i[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        rd_b         = 8'(mem_rd_i >> {core_addr_i[1:0], 3'b000});
        rd_h         = core_addr_i[1] ? mem_rd_i[31:16] : mem_rd_i[15:0];
        core_rd_o    = !done ? '0 :
                       is_b  ? {{24{rd_b[7] & sext}}, rd_b} :
                       is_h  ? {{16{rd_h[15] & sext}}, rd_h} : mem_rd_i;
        core_stall_o = core_req_i & ~done;
        mem_req_o    = core_req_i | in_wait;
        mem_we_o     = core_req_i & core_we_i;
        mem_be_o     = mem_we_o ? be : '0;
        mem_addr_o   = core_addr_i;
        mem_wd_o     = is_b ? {4{core_wd_i[7:0]}} : is_h ? {2{core_wd_i[15:0]}} : core_wd_i;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed vectors checked against a byte-lane arithmetic model every cycle
module tb_load_store_unit;
    logic        clk = 0, rst = 1;
    logic        core_req = 0, core_we = 0, mem_ready = 0;
    logic [2:0]  core_size = 0;
    logic [31:0] core_addr = 0, core_wd = 0, mem_rd = 0;
    logic [31:0] core_rd, mem_addr, mem_wd;
    logic        core_stall, mem_req, mem_we;
    logic [3:0]  mem_be;
    int          vectors = 0, miscompares = 0;
    bit          chk = 0, pending = 0;

    load_store_unit dut (
        .clk_i(clk), .rst_i(rst), .core_req_i(core_req), .core_we_i(core_we),
        .core_size_i(core_size), .core_addr_i(core_addr), .core_wd_i(core_wd),
        .core_rd_o(core_rd), .core_stall_o(core_stall), .mem_req_o(mem_req),
        .mem_we_o(mem_we), .mem_be_o(mem_be), .mem_addr_o(mem_addr),
        .mem_wd_o(mem_wd), .mem_rd_i(mem_rd), .mem_ready_i(mem_ready)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int nb(input logic [2:0] s);
        return (s == 0 || s == 4) ? 1 : (s == 1 || s == 5) ? 2 : 4;
    endfunction

    function automatic int lane(input logic [2:0] s, input logic [31:0] a);
        return (int'(a[1:0]) / nb(s)) * nb(s);
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] s, input logic [31:0] a, input logic [31:0] rd);
        longint n = nb(s);
        longint v = (longint'(rd) >> (8 * lane(s, a))) & ((64'd1 << (8 * n)) - 1);
        if (!s[2] && n < 4 && v >= (64'd1 << (8 * n - 1))) v -= (64'd1 << (8 * n));
        return v[31:0];
    endfunction

    function automatic logic [3:0] exp_be(input logic [2:0] s, input logic [31:0] a);
        logic [3:0] b = '0;
        for (int i = 0; i < 4; i++) b[i] = (i >= lane(s, a)) && (i < lane(s, a) + nb(s));
        return b;
    endfunction

    function automatic logic [31:0] exp_wd(input logic [2:0] s, input logic [31:0] wd);
        logic [31:0] w = '0;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = 8'(wd >> (8 * (i % nb(s))));
        return w;
    endfunction

    // an access is outstanding from the cycle after issue until memory answers it
    always @(posedge clk) begin
        if (rst) pending <= 0;
        else if (!pending) pending <= core_req;
        else if (mem_ready) pending <= 0;
    end

    always @(negedge clk) begin
        bit dn;
        if (chk) begin
            dn = pending && mem_ready;
            cmp("stall", 32'(core_stall), 32'(core_req && !dn));
            cmp("mem_req", 32'(mem_req), 32'(core_req || pending));
            cmp("mem_we", 32'(mem_we), 32'(core_req && core_we));
            cmp("mem_be", 32'(mem_be), (core_req && core_we) ? 32'(exp_be(core_size, core_addr)) : 32'd0);
            cmp("mem_addr", mem_addr, core_addr);
            cmp("mem_wd", mem_wd, exp_wd(core_size, core_wd));
            cmp("core_rd", core_rd, dn ? exp_load(core_size, core_addr, mem_rd) : 32'd0);
        end
    end

    // called 1 time unit after a rising edge; leaves control at the same point
    task automatic acc(input bit we, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] rdata, input int lat, input bit hold,
                       input logic [31:0] x_rd, input logic [3:0] x_be, input logic [31:0] x_wd);
        int stalls = 0;
        core_req = 1; core_we = we; core_size = sz; core_addr = a; core_wd = wd; mem_rd = rdata;
        for (int c = 0; c <= lat; c++) begin
            mem_ready = (c == lat);
            @(negedge clk);
            if (core_stall) stalls++;
            if (c == 0) begin
                cmp("lit_be", 32'(mem_be), 32'(x_be));
                cmp("lit_wd", mem_wd, x_wd);
            end
            if (c == lat) cmp("lit_rd", core_rd, x_rd);
            @(posedge clk); #1;
        end
        cmp("lit_stall_cycles", stalls, lat);
        mem_ready = 0;
        if (!hold) core_req = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        @(posedge clk); #1;
        chk = 1;
        @(negedge clk);
        cmp("rst_stall", 32'(core_stall), 32'd0);
        cmp("rst_mem_req", 32'(mem_req), 32'd0);
        cmp("rst_be", 32'(mem_be), 32'd0);
        @(posedge clk); #1;
        rst = 0;
        @(posedge clk); #1;
        acc(0, 3'd2, 32'h10, 0, 32'hDEADBEEF, 1, 0, 32'hDEADBEEF, 4'b0000, 32'h0);
        acc(0, 3'd0, 32'h3, 0, 32'h80FF7F01, 1, 0, 32'hFFFFFF80, 4'b0000, 32'h0);
        acc(0, 3'd4, 32'h3, 0, 32'h80FF7F01, 1, 0, 32'h00000080, 4'b0000, 32'h0);
        acc(0, 3'd1, 32'h2, 0, 32'h80FF7F01, 1, 0, 32'hFFFF80FF, 4'b0000, 32'h0);
        acc(0, 3'd5, 32'h0, 0, 32'h80FF7F01, 1, 0, 32'h00007F01, 4'b0000, 32'h0);
        acc(0, 3'd0, 32'h1, 0, 32'h80FF7F01, 1, 0, 32'h0000007F, 4'b0000, 32'h0);
        acc(0, 3'd1, 32'h3, 0, 32'h80FF7F01, 1, 0, 32'hFFFF80FF, 4'b0000, 32'h0);
        acc(0, 3'd6, 32'h3, 0, 32'h80FF7F01, 1, 0, 32'h80FF7F01, 4'b0000, 32'h0);
        acc(1, 3'd0, 32'h2, 32'h12345678, 0, 1, 0, 32'h0, 4'b0100, 32'h78787878);
        acc(1, 3'd1, 32'h2, 32'h12345678, 0, 1, 0, 32'h0, 4'b1100, 32'h56785678);
        acc(1, 3'd2, 32'h11, 32'h12345678, 0, 1, 0, 32'h0, 4'b1111, 32'h12345678);
        acc(1, 3'd0, 32'h0, 32'h12345678, 0, 1, 0, 32'h0, 4'b0001, 32'h78787878);
        acc(1, 3'd1, 32'h1, 32'h12345678, 0, 1, 0, 32'h0, 4'b0011, 32'h56785678);
        acc(1, 3'd7, 32'h2, 32'h12345678, 0, 1, 0, 32'h0, 4'b1111, 32'h12345678);
        acc(0, 3'd2, 32'h40, 0, 32'hA5A55A5A, 4, 0, 32'hA5A55A5A, 4'b0000, 32'h0);
        acc(0, 3'd2, 32'h44, 0, 32'h01020304, 1, 1, 32'h01020304, 4'b0000, 32'h0);
        acc(0, 3'd4, 32'h45, 0, 32'h0000F100, 1, 0, 32'h000000F1, 4'b0000, 32'h0);
        // ready while idle must not release the stall
        core_req = 1; core_we = 0; core_size = 3'd2; core_addr = 32'h50; mem_rd = 32'hCAFEF00D; mem_ready = 1;
        @(negedge clk);
        cmp("idle_rdy_stall", 32'(core_stall), 32'd1);
        cmp("idle_rdy_rd", core_rd, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        cmp("idle_rdy_release", 32'(core_stall), 32'd0);
        cmp("idle_rdy_data", core_rd, 32'hCAFEF00D);
        @(posedge clk); #1;
        core_req = 0; mem_ready = 0;
        // reset while waiting, then a stray ready
        @(posedge clk); #1;
        core_req = 1; core_addr = 32'h20; mem_rd = 32'h11112222;
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        rst = 0; core_req = 0; mem_ready = 1;
        @(negedge clk);
        cmp("rstw_stall", 32'(core_stall), 32'd0);
        cmp("rstw_rd", core_rd, 32'd0);
        cmp("rstw_mem_req", 32'(mem_req), 32'd0);
        @(posedge clk); #1;
        mem_ready = 0;
        acc(0, 3'd1, 32'h22, 0, 32'h8001FFFF, 2, 0, 32'hFFFF8001, 4'b0000, 32'h0);
        @(posedge clk); #1;
        chk = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Load/store unit between the RISC-V core's data port and the data memory, which is sized by `DATA_MEM_SIZE_BYTES` (2048) in `memory_pkg`. It is the initiator on the memory request/ready interface.
- Converts core byte, halfword and word accesses into word-aligned memory requests with byte enables and replicated write data.
- Stalls the core until the memory signals ready.
- Extracts, then sign- or zero-extends, load data.

## Interface
Parameters:
- none. The address is passed through full-width; range checking belongs to the data memory.

Ports:
- `clk_i` in 1: system clock; all state changes on its rising edge.
- `rst_i` in 1: synchronous, active-high reset.
- `core_req_i` in 1: core requests a memory access this cycle.
- `core_we_i` in 1: 1 = store, 0 = load.
- `core_size_i` in 3: RISC-V funct3 size code.
  - 0 = B, 1 = H, 2 = W, 4 = BU, 5 = HU.
  - Other codes are treated as W.
- `core_addr_i` in 32: byte address.
- `core_wd_i` in 32: store data, right-aligned.
- `core_rd_o` out 32: load result, extended to 32 bits.
- `core_stall_o` out 1: core must hold the PC and all `core_*` inputs while high.
- `mem_req_o` out 1: memory request.
- `mem_we_o` out 1: memory write enable.
- `mem_be_o` out 4: byte enables.
- `mem_addr_o` out 32: address to memory, equal to `core_addr_i`. The memory ignores bits [1:0].
- `mem_wd_o` out 32: replicated write data.
- `mem_rd_i` in 32: memory read word, valid in the cycle `mem_ready_i` is high.
- `mem_ready_i` in 1: memory completes the outstanding request.

## Operation
- FSM has two states: IDLE and WAIT. Reset value is IDLE.
- IDLE:
  - `core_req_i`=1 → `mem_req_o`=1 combinationally, `core_stall_o`=1; next state WAIT.
  - `core_req_i`=0 → stay in IDLE; all `mem_*` strobes are 0.
- WAIT:
  - `mem_req_o`=1.
  - `mem_ready_i`=1 → `core_stall_o`=0 in this same cycle, `core_rd_o` is valid; next state IDLE.
  - `mem_ready_i`=0 → stay in WAIT with stall held.
- Stall equation: `core_stall_o` = `core_req_i` & ~(state==WAIT & `mem_ready_i`).
- `mem_we_o` = `core_req_i` & `core_we_i`.
- `mem_be_o` is meaningful only when `mem_we_o`=1; otherwise it is driven to 0.
  - B: 4'b0001 << addr[1:0].
  - H: addr[1] ? 4'b1100 : 4'b0011.
  - W: 4'b1111.
- `mem_wd_o`:
  - B: {4{wd[7:0]}}.
  - H: {2{wd[15:0]}}.
  - W: wd.
- Load extraction uses lane `mem_rd_i[8*addr[1:0] +: 8]`, or `mem_rd_i[16*addr[1] +: 16]` for halfwords.
  - B/H: sign-extend.
  - BU/HU: zero-extend.
  - W: pass through.
- Misalignment:
  - addr[0] is ignored for H/HU.
  - addr[1:0] is ignored for W.
  - No trap is raised; the core is responsible for alignment.

## Timing
- Reset values: state=IDLE, `core_stall_o`=`core_req_i` (0 when idle), `mem_req_o`=0, `mem_we_o`=0, `mem_be_o`=0, `core_rd_o`=0 while `mem_ready_i`=0.
- Minimum access time is 2 cycles.
  - Cycle 0: request issued, stall=1.
  - Cycle 1: memory is ready, stall=0, data valid.
- Each extra cycle with `mem_ready_i`=0 adds one stall cycle. There is no timeout.
- `mem_ready_i` while in IDLE is ignored and does not release a stall.
- Back-to-back accesses: after the releasing cycle the FSM is in IDLE. If `core_req_i` is still 1, a new access starts and stall asserts again in that cycle.
- `core_req_i` dropping while in WAIT (illegal for the core): the next state is still decided by `mem_ready_i`, and the FSM returns to IDLE on ready.
- Reset mid-access: the FSM returns to IDLE in the next cycle. Any `mem_ready_i` arriving later is ignored.
- Reset has priority over every other transition.

## Test plan
- Load word:
  - Stimulus: addr=0x10, `mem_rd_i`=0xDEADBEEF, ready 1 cycle after request.
  - Response: stall high exactly 1 cycle, then `core_rd_o`=0xDEADBEEF with stall=0.
- Byte and halfword loads, `mem_rd_i`=0x80FF7F01:
  - LB addr=0x3 → 0xFFFFFF80.
  - LBU addr=0x3 → 0x00000080.
  - LH addr=0x2 → 0xFFFF80FF.
  - LHU addr=0x0 → 0x00007F01.
- Stores, wd=0x12345678:
  - SB addr=0x2 → be=0100, `mem_wd_o`=0x78787878.
  - SH addr=0x2 → be=1100, `mem_wd_o`=0x56785678.
  - SW → be=1111, `mem_wd_o`=0x12345678.
- Slow memory: ready asserted 4 cycles after request → stall high for 4 cycles; `mem_req_o` stays 1 throughout.
- Back-to-back: two loads with `core_req_i` held high → stall pattern 1,0,1,0 with immediate ready.
- Reset in WAIT:
  - Stimulus: `rst_i` asserted 1 cycle, then `mem_ready_i` pulsed with `core_req_i`=0.
  - Response: state IDLE, stall=0, no spurious `core_rd_o` capture.
